// File: rtl/program_ram.sv
// Writable TD4 program memory: combinational fetch port, byte-serial loader with
// valid/ready handshake, and an automatic zero-fill of the array after reset.
module program_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  N_RESET,
    input  logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] D,
    output logic                  CPU_HOLD,
    input  logic                  LD_START,
    input  logic                  LD_ABORT,
    input  logic                  LD_VALID,
    input  logic [DATA_WIDTH-1:0] LD_DATA,
    output logic                  LD_READY,
    output logic [ADDR_WIDTH-1:0] LD_ADDR,
    output logic                  LD_DONE,
    output logic [DATA_WIDTH-1:0] CHECKSUM
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_LOAD
    } state_t;

    state_t                state_reg;
    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic [DATA_WIDTH-1:0] checksum_reg;
    logic                  done_reg;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Abort takes priority over a valid beat in the same cycle.
    assign accept = (state_reg == ST_LOAD) && LD_VALID && !LD_ABORT;

    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (state_reg == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (accept) begin
            mem_we    = 1'b1;
            mem_wdata = LD_DATA;
        end
    end

    // Array has no reset; a write is suppressed on a reset edge so reset wins.
    always_ff @(posedge CLK) begin
        if (N_RESET && mem_we) begin
            mem[ptr_reg] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (!N_RESET) begin
            state_reg    <= ST_CLEAR;
            ptr_reg      <= '0;
            checksum_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_CLEAR: begin
                    if (ptr_reg == LAST_ADDR) begin
                        state_reg <= ST_RUN;
                        ptr_reg   <= '0;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (LD_START) begin
                        state_reg    <= ST_LOAD;
                        ptr_reg      <= '0;
                        checksum_reg <= '0;
                    end
                end
                ST_LOAD: begin
                    if (LD_ABORT) begin
                        state_reg <= ST_RUN;
                        ptr_reg   <= '0;
                    end else if (LD_VALID) begin
                        checksum_reg <= checksum_reg + LD_DATA;
                        if (ptr_reg == LAST_ADDR) begin
                            state_reg <= ST_RUN;
                            ptr_reg   <= '0;
                            done_reg  <= 1'b1;
                        end else begin
                            ptr_reg <= ptr_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_CLEAR;
                    ptr_reg   <= '0;
                end
            endcase
        end
    end

    assign D        = (state_reg == ST_RUN) ? mem[A] : '0;
    assign CPU_HOLD = (state_reg != ST_RUN);
    assign LD_READY = (state_reg == ST_LOAD) && !LD_ABORT;
    assign LD_ADDR  = ptr_reg;
    assign LD_DONE  = done_reg;
    assign CHECKSUM = checksum_reg;
endmodule

// File: tb/tb_program_ram.sv
// Directed bench for program_ram: clear after reset, full and gapped loads,
// abort, reset during a load, and ignored requests, with table-driven readback.
module tb_program_ram;
    logic       CLK;
    logic       N_RESET;
    logic [3:0] A;
    logic [7:0] D;
    logic       CPU_HOLD;
    logic       LD_START;
    logic       LD_ABORT;
    logic       LD_VALID;
    logic [7:0] LD_DATA;
    logic       LD_READY;
    logic [3:0] LD_ADDR;
    logic       LD_DONE;
    logic [7:0] CHECKSUM;

    program_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .CLK      (CLK),
        .N_RESET  (N_RESET),
        .A        (A),
        .D        (D),
        .CPU_HOLD (CPU_HOLD),
        .LD_START (LD_START),
        .LD_ABORT (LD_ABORT),
        .LD_VALID (LD_VALID),
        .LD_DATA  (LD_DATA),
        .LD_READY (LD_READY),
        .LD_ADDR  (LD_ADDR),
        .LD_DONE  (LD_DONE),
        .CHECKSUM (CHECKSUM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int         phase;
        logic [3:0] a;
        logic [7:0] exp_d;
    } rd_vec_t;

    rd_vec_t rd_vecs[$];
    int      vec_count;
    int      miss_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check_reset_state();
        A = 4'd7;
        #1;
        check("rst_hold", 32'(CPU_HOLD), 32'd1);
        check("rst_ready", 32'(LD_READY), 32'd0);
        check("rst_done", 32'(LD_DONE), 32'd0);
        check("rst_addr", 32'(LD_ADDR), 32'd0);
        check("rst_csum", 32'(CHECKSUM), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        $display("reset state checked");
    endtask

    // Called right after N_RESET is released; optionally pokes loader inputs mid-clear.
    task automatic wait_clear(input bit poke);
        for (int i = 1; i <= 16; i++) begin
            LD_START = poke && (i == 5);
            LD_VALID = poke && (i == 6);
            LD_DATA  = 8'h5A;
            A        = 4'(i - 1);
            #1;
            check("clear_ready", 32'(LD_READY), 32'd0);
            check("clear_d", 32'(D), 32'd0);
            tick();
            LD_START = 1'b0;
            LD_VALID = 1'b0;
            check("clear_hold", 32'(CPU_HOLD), (i < 16) ? 32'd1 : 32'd0);
            check("clear_addr", 32'(LD_ADDR), (i < 16) ? 32'(i) : 32'd0);
            check("clear_done", 32'(LD_DONE), 32'd0);
        end
        $display("clear sequence finished, hold=%0d", CPU_HOLD);
    endtask

    task automatic apply_phase(input int p);
        for (int i = 0; i < rd_vecs.size(); i++) begin
            if (rd_vecs[i].phase == p) begin
                A = rd_vecs[i].a;
                #1;
                check("readback", 32'(D), 32'(rd_vecs[i].exp_d));
                $display("rd phase %0d A=%0d D=%02h exp=%02h", p, A, D, rd_vecs[i].exp_d);
            end
        end
    endtask

    task automatic run_load(input logic [7:0] first, input logic [7:0] step, input int n,
                            input bit gaps, input bit start_mid, input bit abort_with_start);
        logic [7:0] data;
        LD_START = 1'b1;
        LD_ABORT = abort_with_start;
        tick();
        LD_START = 1'b0;
        LD_ABORT = 1'b0;
        A = 4'd3;
        #1;
        check("start_hold", 32'(CPU_HOLD), 32'd1);
        check("start_ready", 32'(LD_READY), 32'd1);
        check("start_addr", 32'(LD_ADDR), 32'd0);
        check("start_csum", 32'(CHECKSUM), 32'd0);
        check("load_d_zero", 32'(D), 32'd0);
        data = first;
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0) begin
                LD_VALID = 1'b0;
                tick();
                check("gap_addr", 32'(LD_ADDR), 32'(k));
                check("gap_done", 32'(LD_DONE), 32'd0);
            end
            LD_VALID = 1'b1;
            LD_DATA  = data;
            LD_START = start_mid && (k == 7);
            #1;
            check("beat_ready", 32'(LD_READY), 32'd1);
            tick();
            LD_START = 1'b0;
            $display("beat %0d data=%02h addr_after=%0d", k, data, LD_ADDR);
            if (k == 15) begin
                check("final_done", 32'(LD_DONE), 32'd1);
                check("final_hold", 32'(CPU_HOLD), 32'd0);
                check("final_addr", 32'(LD_ADDR), 32'd0);
            end else begin
                check("beat_done", 32'(LD_DONE), 32'd0);
                check("beat_hold", 32'(CPU_HOLD), 32'd1);
                check("beat_addr", 32'(LD_ADDR), 32'(k + 1));
            end
            data = data + step;
        end
        LD_VALID = 1'b0;
        if (n == 16) begin
            tick();
            check("done_pulse_end", 32'(LD_DONE), 32'd0);
        end
    endtask

    initial begin
        vec_count  = 0;
        miss_count = 0;
        for (int i = 0; i < 16; i++) begin
            rd_vecs.push_back('{0, 4'(i), 8'h00});
            rd_vecs.push_back('{1, 4'(i), 8'(i + 1)});
            rd_vecs.push_back('{2, 4'(i), 8'(8'hF0 + i)});
            rd_vecs.push_back('{3, 4'(i), (i < 5) ? 8'hFF : 8'(i + 1)});
            rd_vecs.push_back('{4, 4'(i), 8'h00});
        end

        N_RESET  = 1'b0;
        A        = '0;
        LD_START = 1'b0;
        LD_ABORT = 1'b0;
        LD_VALID = 1'b0;
        LD_DATA  = '0;

        // Reset and clear, with loader requests poked mid-clear
        tick();
        tick();
        check_reset_state();
        N_RESET = 1'b1;
        wait_clear(1'b1);
        apply_phase(0);

        // Full load, LD_START pulsed mid-load must not rewind the pointer
        run_load(8'h01, 8'h01, 16, 1'b0, 1'b1, 1'b0);
        check("full_csum", 32'(CHECKSUM), 32'h88);
        // Valid and abort in RUN are ignored
        LD_VALID = 1'b1;
        LD_ABORT = 1'b1;
        LD_DATA  = 8'h55;
        #1;
        check("run_ready", 32'(LD_READY), 32'd0);
        tick();
        LD_VALID = 1'b0;
        LD_ABORT = 1'b0;
        check("run_hold", 32'(CPU_HOLD), 32'd0);
        check("run_csum_hold", 32'(CHECKSUM), 32'h88);
        apply_phase(1);

        // Gapped load; start issued together with abort (start wins in RUN)
        run_load(8'hF0, 8'h01, 16, 1'b1, 1'b0, 1'b1);
        check("gap_csum", 32'(CHECKSUM), 32'h78);
        apply_phase(2);

        // Abort after 5 beats of 0xFF, over a fresh 0x01..0x10 image
        run_load(8'h01, 8'h01, 16, 1'b0, 1'b0, 1'b0);
        run_load(8'hFF, 8'h00, 5, 1'b0, 1'b0, 1'b0);
        LD_VALID = 1'b1;
        LD_ABORT = 1'b1;
        LD_DATA  = 8'hAA;
        #1;
        check("abort_ready", 32'(LD_READY), 32'd0);
        tick();
        LD_VALID = 1'b0;
        LD_ABORT = 1'b0;
        check("abort_hold", 32'(CPU_HOLD), 32'd0);
        check("abort_done", 32'(LD_DONE), 32'd0);
        check("abort_addr", 32'(LD_ADDR), 32'd0);
        check("abort_csum", 32'(CHECKSUM), 32'hFB);
        tick();
        check("abort_done2", 32'(LD_DONE), 32'd0);
        check("abort_csum2", 32'(CHECKSUM), 32'hFB);
        apply_phase(3);

        // Reset after 8 accepted beats, with a beat offered on the reset edge
        run_load(8'h11, 8'h11, 8, 1'b0, 1'b0, 1'b0);
        N_RESET  = 1'b0;
        LD_VALID = 1'b1;
        LD_DATA  = 8'h77;
        tick();
        N_RESET  = 1'b1;
        LD_VALID = 1'b0;
        check_reset_state();
        wait_clear(1'b0);
        check("midrst_csum", 32'(CHECKSUM), 32'd0);
        apply_phase(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
